// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings, bridge state type and small mapping helpers
// used by the AHB-Lite to APB bridge and its address decoder.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // APB PPROT = {instruction/data, secure (always 0), privileged}
  function automatic logic [2:0] pprot_map(input logic [1:0] hprot_lo);
    return {~hprot_lo[0], 1'b0, hprot_lo[1]};
  endfunction

  function automatic logic [3:0] strb_map(input logic [1:0] hsize, input logic [1:0] addr_lo);
    case (hsize)
      HSIZE_BYTE[1:0]: return 4'b0001 << addr_lo;
      HSIZE_HALF[1:0]: return 4'b0011 << {addr_lo[1], 1'b0};
      default:         return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational region decoder: maps HADDR[31:16] onto a one-hot slave
// select, lowest index winning when regions overlap.
module apb_addr_decoder #(
  parameter int                  P_NUM        = 4,
  parameter logic [16*P_NUM-1:0] P_ADDR_START = {16'h3000, 16'h2000, 16'h1000, 16'h0000},
  parameter logic [16*P_NUM-1:0] P_ADDR_SIZE  = {4{16'h0010}}
) (
  input  logic [15:0]      addr_hi,
  output logic [P_NUM-1:0] sel,
  output logic             miss
);

  logic [P_NUM-1:0] hit;

  for (genvar gi = 0; gi < P_NUM; gi++) begin : g_hit
    logic [16:0] region_end;
    // 17-bit end so a region touching 16'hFFFF does not wrap to zero
    assign region_end = {1'b0, P_ADDR_START[16*gi +: 16]} + {1'b0, P_ADDR_SIZE[16*gi +: 16]};
    assign hit[gi]    = (addr_hi >= P_ADDR_START[16*gi +: 16]) && ({1'b0, addr_hi} < region_end);
  end

  // isolate the lowest set bit of hit
  assign sel  = hit & (~hit + P_NUM'(1));
  assign miss = ~|hit;

endmodule

// File: rtl/ahb_to_apb_sn.sv
// AHB-Lite slave to APB3/APB4 bridge for P_NUM APB slaves on one clock,
// with decode/size errors, PSLVERR propagation and an optional ACCESS watchdog.
module ahb_to_apb_sn
  import ahb_apb_pkg::*;
#(
  parameter int                  P_NUM        = 4,
  parameter logic [16*P_NUM-1:0] P_ADDR_START = {16'h3000, 16'h2000, 16'h1000, 16'h0000},
  parameter logic [16*P_NUM-1:0] P_ADDR_SIZE  = {4{16'h0010}},
  parameter int                  P_TIMEOUT    = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [3:0]           HPROT,
  input  logic [31:0]          HWDATA,
  input  logic                 HREADYin,
  output logic                 HREADYout,
  output logic [1:0]           HRESP,
  output logic [31:0]          HRDATA,
  output logic [P_NUM-1:0]     PSEL,
  output logic [31:0]          PADDR,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  output logic [2:0]           PPROT,
  input  logic [32*P_NUM-1:0]  PRDATA,
  input  logic [P_NUM-1:0]     PREADY,
  input  logic [P_NUM-1:0]     PSLVERR
);

  localparam int            CW     = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(P_TIMEOUT);

  state_e            state_q, state_d;
  logic              hreadyout_q, hreadyout_d;
  logic [1:0]        hresp_q, hresp_d;
  logic [31:0]       hrdata_q, hrdata_d;
  logic [P_NUM-1:0]  psel_q, psel_d;
  logic [31:0]       paddr_q, paddr_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [3:0]        pstrb_q, pstrb_d;
  logic [2:0]        pprot_q, pprot_d;
  logic [31:0]       haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [1:0]        hsize_q, hsize_d;
  logic [2:0]        lat_pprot_q, lat_pprot_d;
  logic [P_NUM-1:0]  sel_q, sel_d;
  logic              miss_q, miss_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [P_NUM-1:0]  dec_sel;
  logic              dec_miss;
  logic              accept;
  logic              pready_sel, pslverr_sel;
  logic [31:0]       prdata_sel;
  logic [CW-1:0]     cnt_inc;
  logic              unused_hprot;

  apb_addr_decoder #(
    .P_NUM        (P_NUM),
    .P_ADDR_START (P_ADDR_START),
    .P_ADDR_SIZE  (P_ADDR_SIZE)
  ) u_decoder (
    .addr_hi (HADDR[31:16]),
    .sel     (dec_sel),
    .miss    (dec_miss)
  );

  assign accept       = HSEL && HREADYin && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign pready_sel   = |(PREADY & sel_q);
  assign pslverr_sel  = |(PSLVERR & sel_q);
  assign cnt_inc      = cnt_q + CW'(1);
  assign unused_hprot = ^HPROT[3:2];

  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < P_NUM; i++) begin
      if (sel_q[i]) prdata_sel = PRDATA[32*i +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    hrdata_d    = hrdata_q;
    psel_d      = psel_q;
    paddr_d     = paddr_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    lat_pprot_d = lat_pprot_q;
    sel_d       = sel_q;
    miss_d      = miss_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept) begin
          haddr_d     = HADDR;
          hwrite_d    = HWRITE;
          hsize_d     = HSIZE[1:0];
          lat_pprot_d = pprot_map(HPROT[1:0]);
          sel_d       = dec_sel;
          miss_d      = dec_miss || (HSIZE > HSIZE_WORD);
          state_d     = ST_LATCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (miss_q) begin
          state_d = ST_ERR1;
        end else begin
          psel_d   = sel_q;
          paddr_d  = haddr_q;
          pwrite_d = hwrite_q;
          pprot_d  = lat_pprot_q;
          pstrb_d  = hwrite_q ? strb_map(hsize_q, haddr_q[1:0]) : 4'h0;
          if (hwrite_q) pwdata_d = HWDATA;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_sel) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (pslverr_sel) begin
            state_d = ST_ERR1;
          end else begin
            if (!hwrite_q) hrdata_d = prdata_sel;
            state_d = ST_IDLE;
          end
        end else if (P_TIMEOUT > 0 && cnt_inc == TO_VAL) begin
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = ST_ERR1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    // AHB response flops track the state being entered
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d     = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      psel_q      <= '0;
      paddr_q     <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      lat_pprot_q <= '0;
      sel_q       <= '0;
      miss_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      psel_q      <= psel_d;
      paddr_q     <= paddr_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      lat_pprot_q <= lat_pprot_d;
      sel_q       <= sel_d;
      miss_q      <= miss_d;
      cnt_q       <= cnt_d;
    end
  end

  assign HREADYout = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PSEL      = psel_q;
  assign PADDR     = paddr_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PPROT     = pprot_q;

endmodule
